// File: rtl/mult_div_unit_if.sv
// HI/LO unit bus: operation launch, MTHI/MTLO writes and HI/LO/status readback.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic             WriteHi;
    logic             WriteLo;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Start, Op, ReadData1, ReadData2, WriteHi, WriteLo,
        input  Hi, Lo, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Op, ReadData1, ReadData2, WriteHi, WriteLo,
        output Hi, Lo, Busy, Done, DivByZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO registers.
// Sign handling is magnitude-based: operands are made positive on launch and fixed up once at the end.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   add_sum, mul_t, rem_sh, diff;
    logic [WIDTH-1:0] quot, rem;
    logic [2*WIDTH-1:0] prod;

    assign is_signed = ~bus.Op[0];
    assign a_neg     = is_signed & bus.ReadData1[WIDTH-1];
    assign b_neg     = is_signed & bus.ReadData2[WIDTH-1];

    // acc/mq double as {partial product, multiplier} and {partial remainder, quotient}
    assign add_sum = acc_q + {1'b0, b_q};
    assign mul_t   = mq_q[0] ? add_sum : acc_q;
    assign rem_sh  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};

    assign prod = {acc_q[WIDTH-1:0], mq_q};
    assign quot = (sa_q ^ sb_q) ? -mq_q : mq_q;
    assign rem  = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    div_d   = bus.Op[1];
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    a_d     = bus.ReadData1;
                    b_d     = b_neg ? -bus.ReadData2 : bus.ReadData2;
                    mq_d    = a_neg ? -bus.ReadData1 : bus.ReadData1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = S_CALC;
                end else begin
                    if (bus.WriteHi) hi_d = bus.ReadData1;
                    if (bus.WriteLo) lo_d = bus.ReadData1;
                end
            end
            S_CALC: begin
                if (div_q) begin
                    acc_d = diff[WIDTH] ? rem_sh : diff;
                    mq_d  = {mq_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    acc_d = {1'b0, mul_t[WIDTH:1]};
                    mq_d  = {mul_t[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    if (b_q == '0) begin
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                end else begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod : prod;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
endmodule
